// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter with a registered valid/ready output stage.
// Each transfer runs IDLE -> HOLD -> ACK, so there is at most one owner per word.
module bus_arbiter4 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       grant,
    output logic [3:0]       ack
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StAck  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       ack_q, ack_d;

    logic [1:0]       win_idx;
    logic [WIDTH-1:0] win_data;

    // Scan from the farthest offset down so the one closest to ptr wins.
    always_comb begin
        win_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                win_idx = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        unique case (win_idx)
            2'd0:    win_data = data0;
            2'd1:    win_data = data1;
            2'd2:    win_data = data2;
            default: win_data = data3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        grant_d     = grant_q;
        ack_d       = 4'b0000;

        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    state_d     = StHold;
                    owner_d     = win_idx;
                    out_d       = win_data;
                    out_valid_d = 1'b1;
                    grant_d     = 4'b0001 << win_idx;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d     = StAck;
                    out_valid_d = 1'b0;
                    ack_d       = 4'b0001 << owner_q;
                    ptr_d       = owner_q + 2'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                grant_d     = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= 4'b0000;
            ack_q       <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign grant     = grant_q;
    assign ack       = ack_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: reset, single transfer, rotation, skip,
// backpressure and reset during an outstanding transfer.
module tb_bus_arbiter4;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] data0, data1, data2, data3;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  grant;
    logic [3:0]  ack;

    int n_checks;
    int n_errors;

    bus_arbiter4 #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .ack       (ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " valid"}, {15'd0, out_valid}, 16'd0);
        check_eq({tag, " grant"}, {12'd0, grant}, 16'd0);
        check_eq({tag, " ack"}, {12'd0, ack}, 16'd0);
    endtask

    // Three edges of one unstalled transfer from IDLE; out_ready must be high.
    task automatic do_xfer(input string tag, input int idx, input logic [15:0] exp_data);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        step();
        check_eq({tag, " out"}, out, exp_data);
        check_eq({tag, " valid"}, {15'd0, out_valid}, 16'd1);
        check_eq({tag, " grant"}, {12'd0, grant}, {12'd0, oh});
        check_eq({tag, " ack0"}, {12'd0, ack}, 16'd0);
        step();
        check_eq({tag, " ack"}, {12'd0, ack}, {12'd0, oh});
        check_eq({tag, " ackvalid"}, {15'd0, out_valid}, 16'd0);
        check_eq({tag, " ackgrant"}, {12'd0, grant}, {12'd0, oh});
        check_eq({tag, " outheld"}, out, exp_data);
        step();
        check_idle({tag, " idle"});
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b0;
        data0     = 16'h0000;
        data1     = 16'h0001;
        data2     = 16'h0002;
        data3     = 16'h0003;

        // Reset with all requests asserted
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst out", out, 16'h0000);
            check_idle("rst");
        end
        reset = 1'b0;
        req   = 4'b0000;
        #1;
        check_idle("rel");
        step();
        check_eq("rel out", out, 16'h0000);
        check_idle("rel+1");

        // Single requester
        req       = 4'b0100;
        data2     = 16'hBEEF;
        out_ready = 1'b1;
        step();
        check_eq("single out", out, 16'hBEEF);
        check_eq("single valid", {15'd0, out_valid}, 16'd1);
        check_eq("single grant", {12'd0, grant}, 16'h0004);
        step();
        check_eq("single ack", {12'd0, ack}, 16'h0004);
        req = 4'b0000;
        step();
        check_idle("single idle");

        // Reset to bring ptr back to 0 before the rotation test
        reset = 1'b1;
        step();
        reset = 1'b0;
        data2 = 16'h0002;

        // Round robin with all four requesting
        req = 4'b1111;
        do_xfer("rr0", 0, 16'h0000);
        do_xfer("rr1", 1, 16'h0001);
        do_xfer("rr2", 2, 16'h0002);
        do_xfer("rr3", 3, 16'h0003);
        do_xfer("rr4", 0, 16'h0000);

        // ptr is now 1: requester 3 precedes requester 0
        req   = 4'b1001;
        data0 = 16'hA0A0;
        data3 = 16'h3333;
        do_xfer("skip3", 3, 16'h3333);
        do_xfer("skip0", 0, 16'hA0A0);
        req = 4'b0000;

        // Backpressure on requester 1 (ptr is 1)
        req       = 4'b0010;
        data1     = 16'h1234;
        out_ready = 1'b0;
        step();
        check_eq("bp grant", {12'd0, grant}, 16'h0002);
        check_eq("bp out", out, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            data1 = 16'h5000 + 16'(i);
            req   = 4'(4'b1111 - i);
            step();
            check_eq("bp hold out", out, 16'h1234);
            check_eq("bp hold valid", {15'd0, out_valid}, 16'd1);
            check_eq("bp hold grant", {12'd0, grant}, 16'h0002);
            check_eq("bp hold ack", {12'd0, ack}, 16'd0);
        end
        out_ready = 1'b1;
        req       = 4'b0010;
        step();
        check_eq("bp ack", {12'd0, ack}, 16'h0002);
        check_eq("bp ackvalid", {15'd0, out_valid}, 16'd0);
        req = 4'b0000;
        step();
        check_idle("bp idle");

        // ptr is 2; serve requester 0 so ptr becomes 1
        req = 4'b0001;
        do_xfer("pre0", 0, 16'hA0A0);

        // Reset while holding requester 1's word; reset beats out_ready
        req       = 4'b0011;
        data1     = 16'hB1B1;
        out_ready = 1'b0;
        step();
        check_eq("mid grant", {12'd0, grant}, 16'h0002);
        check_eq("mid out", out, 16'hB1B1);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq("mid rst out", out, 16'h0000);
        check_idle("mid rst");
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        check_eq("post rst grant", {12'd0, grant}, 16'h0001);
        check_eq("post rst out", out, 16'hA0A0);
        check_eq("post rst ack", {12'd0, ack}, 16'd0);
        out_ready = 1'b1;
        step();
        check_eq("post rst acked", {12'd0, ack}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Round-robin arbiter and output register that shares one 16-bit word bus among four requesters. It drives a Mux16-style selection tree and sequences each transfer through a valid/ready output handshake. It sits between producer blocks (ALU results, I/O ports) and a single consumer such as a register-file write port or a memory write bus. It guarantees at most one owner per transfer and fair rotation of ownership.

## Interface
- WIDTH, 16, data word width in bits.
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- req  in  4  request per requester; bit i belongs to data{i}.
- data0, data1, data2, data3  in  WIDTH each  word offered by requester i.
- out  out  WIDTH  registered word of the current transfer.
- out_valid  out  1  out holds a word not yet accepted.
- out_ready  in  1  consumer accepts out when out_valid is also high.
- grant  out  4  one-hot current owner; 0 when idle.
- ack  out  4  one-hot, one-cycle pulse: requester i's word was taken.

## Operation
- State machine: IDLE, HOLD, ACK. Internal round-robin pointer ptr, 2 bits.
- IDLE: out_valid=0, grant=0, ack=0.
  - If req==0, stay in IDLE.
  - Otherwise, select winner g as the first set req bit in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Capture data{g} into out, set grant to one-hot g, go to HOLD.
- HOLD: out_valid=1, grant=g, and out is held stable.
  - req and data changes are ignored.
  - If out_ready=1, the transfer completes: go to ACK and set ptr=(g+1) mod 4.
  - Otherwise, stay in HOLD indefinitely.
- ACK: out_valid=0, ack=one-hot g for exactly this cycle, grant=g. Always go to IDLE next.
- Requester protocol:
  - Hold req[i] and data{i} until ack[i] is seen, then deassert req[i] by the next edge.
  - Dropping req[i] during HOLD is a protocol violation. The transfer still completes and is acked.
- ptr advances only on completed transfers, so a requester waits at most 3 other transfers.
- out keeps its last value outside HOLD. Consumers qualify it with out_valid.
- Reset (any state, including mid-HOLD):
  - state=IDLE, ptr=0, out=0, out_valid=0, grant=0, ack=0.
  - A pending word is discarded and is not acked.

## Timing
- Reset values: out=0, out_valid=0, grant=0, ack=0, ptr=0.
- Request to valid latency: req high at edge k (state IDLE) gives out_valid=1 and the captured word after edge k.
- Accept: out_valid and out_ready both high at edge m. After edge m, out_valid=0 and ack[g]=1 for one cycle. After edge m+1, state is IDLE and ack=0.
- Minimum cycle per transfer is 3 clocks (IDLE, HOLD, ACK). Peak throughput is 1 word per 3 cycles.
- A req sampled during HOLD or ACK has no effect until the next IDLE cycle.
- When reset and out_ready are high at the same edge, reset wins: no ack and no ptr update.
- The output path is fully registered: out, out_valid, grant and ack are flops with no combinational path from inputs.

## Test plan
- Reset check: hold reset 2 cycles with req=4'b1111 → out=0, out_valid=0, grant=0, ack=0 throughout and on the first cycle after release.
- Single requester: req=4'b0100, data2=16'hBEEF, out_ready=1.
  - After the 1st edge: out=16'hBEEF, out_valid=1, grant=4'b0100.
  - After the 2nd edge: ack=4'b0100.
  - After the 3rd edge: idle.
- Round robin: req=4'b1111 held, each dataI=16'h000I, out_ready=1 → output order 0,1,2,3,0, each acked once, with 3 cycles between out_valid rises.
- Rotation skip: ptr=1 after serving requester 0, then req=4'b1001 → requester 3 wins before 0. Next grant goes to 0.
- Backpressure: grant requester 1 with data1=16'h1234. Hold out_ready=0 for 5 cycles while changing data1 and req → out stays 16'h1234, out_valid=1, grant=4'b0010, ack=0. Raise out_ready → ack=4'b0010 one cycle later.
- Reset mid-HOLD: in HOLD with out_ready=0, pulse reset for 1 cycle → out_valid=0, no ack pulse, ptr=0. With req=4'b0011 still high, requester 0 is granted on the next IDLE.
